pe_result_drain: RTL
====================

# pe_result_drain

Collects the per-column results leaving the PE array and turns them into aligned rows. Each lane's valid strobe arrives skewed by one cycle per column, so each lane gets its own small FIFO, and a complete row is presented on a valid/ready stream once every lane holds at least one entry. The block sits directly downstream of the PE array and upstream of the output writer.

## Interface
- `ARRAY_NUM`, 3: number of lanes (PE columns); must be at least 2.
- `DEPTH`, 4: entries per lane FIFO; must be a power of two, at least 2.
- `VALID_DLY`, 1: cycles between a lane's valid strobe and its result being stable on `iResult`; range 0..3.

Ports:
- `iClk`  in  1  clock; all state changes on the rising edge.
- `iRstN`  in  1  asynchronous, active-low reset.
- `iResult`  in  8*ARRAY_NUM  lane i result in bits [8i+7:8i].
- `iResultValid`  in  ARRAY_NUM  lane i strobe, one cycle per result.
- `iFlush`  in  1  synchronous flush of all lanes plus clear of `oOverflow`.
- `iReady`  in  1  consumer accepts the row this cycle.
- `oRow`  out  8*ARRAY_NUM  head entry of every lane, same lane packing as `iResult`.
- `oValid`  out  1  every lane FIFO is non-empty.
- `oOverflow`  out  1  sticky flag: a sample was dropped.
- `oLevel`  out  $clog2(DEPTH)+1  number of complete rows (minimum lane count).

## Operation
- **Qualifying a sample**
  - Per lane, `iResultValid[i]` passes through a shift register of length `VALID_DLY`; call the result `q[i]`.
  - When `VALID_DLY` = 0, `q[i]` = `iResultValid[i]` with no register.
  - When `q[i]` = 1, `iResult` lane i is pushed into FIFO i in that same cycle.
- **Pop**
  - A pop occurs when `oValid` and `iReady` are both 1.
  - A pop removes the head of every lane at once.
- **Full lane**
  - A push to a full lane with no pop that cycle is dropped.
  - `oOverflow` is set and stays 1 until `iFlush` or reset.
  - The other lanes are unaffected, so the lanes are misaligned from then on. Software must flush.
- **Full lane with simultaneous pop**: the push is accepted and the lane count is unchanged.
- **Flush**
  - `iFlush` has priority over push and pop in the same cycle.
  - It empties all lanes, clears `oOverflow`, and clears the delay shift registers, so any in-flight strobes are discarded.
- **Output encoding**
  - `oRow` is the head data of each lane.
  - When `oValid` = 0, `oRow` holds the last head contents and is ignored by the consumer.
- **Stream rules**: a producer-side stall does not exist. `oValid` never drops while `iReady` = 0, unless `iFlush` is asserted.

## Timing
- **Reset values**: all counts and pointers 0, memories 0, `oRow` = 0, `oValid` = 0, `oOverflow` = 0, `oLevel` = 0.
- **Push latency**: a push at edge k makes the entry visible from k+1. If it completes a row, `oValid` = 1 in the cycle after edge k.
- **Throughput**: `oValid` and `oLevel` are decoded from registered counts, with no combinational path from inputs. One row per cycle is sustained when `iReady` = 1.
- **Reset mid-operation**: reset takes effect immediately, independent of the clock. The first push is accepted at the first edge after `iRstN` is released.

## Structure
- **Shared package `pe_pkg`**:
  - `DATA_W` = 8
  - lane-slice helper constants
  - the `VALID_DLY` range limit
- **Sub-module `lane_fifo`**:
  - a DEPTH×8 synchronous FIFO with push, pop, flush, count, full and empty;
  - instantiated `ARRAY_NUM` times by a generate loop.
- **Top level** contains the delay shift registers, the `oValid`/`oLevel` reduction, and the overflow flag.

## Test plan
1. **Skewed row**: `ARRAY_NUM`=3, `VALID_DLY`=1, `iReady`=1. Strobe lanes 0/1/2 at cycles 0/1/2; lane data 0x11/0x22/0x33 appears in cycles 1/2/3. Required: `oValid`=1 in cycle 4 only, with `oRow`=0x332211.
2. **Backpressure to full**: `iReady`=0, `DEPTH`=4. Send 4 rows. Required: `oLevel`=4 and `oOverflow`=0. A 5th row is dropped and `oOverflow`=1. Raising `iReady` pops the 4 original rows in order.
3. **Push with pop on a full lane**: fill `DEPTH` rows, then push lane 0 in the same cycle as a pop. Required: lane 0 count stays 4, no overflow, and the new value is at the tail.
4. **Back-to-back rows**: strobes on every cycle for 8 cycles, `iReady`=1. Required: 8 rows out, contiguous, in order, with `oLevel` never above 1.
5. **Flush mid-row**: only lane 0 pushed, then `iFlush`=1 while a lane 1 strobe is pending in the delay register. Required: all counts 0, `oValid`=0, and the pending strobe is discarded.
6. **Async reset mid-stream**: drop `iRstN` between clock edges while 2 rows are held. Required: `oValid`, `oLevel` and `oOverflow` go to 0 before the next edge.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared constants for the PE result drain path.
// Provides the lane data width, lane slicing helper and the valid-delay limit.
package pe_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned VALID_DLY_MAX = 3;

  // Bit offset of a lane inside a packed lane bus.
  function automatic int unsigned lane_lsb(input int unsigned lane);
    return lane * DATA_W;
  endfunction

endpackage

// File: rtl/pe_result_drain_lane_fifo.sv
// Single-lane synchronous FIFO with registered head data.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write;
// pop_i removes head; flush_i empties (wins over push/pop); head_o current
// head (holds last head when empty); count_o/full_o/empty_o occupancy.
module lane_fifo
  import pe_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [DATA_W-1:0]       data_i,
  output logic [DATA_W-1:0]       head_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              push_ok, pop_ok;

  // Next-state: pointers, count and the head value visible after this edge.
  always_comb begin
    pop_ok   = pop_i && (count_q != '0);
    // A full lane still accepts a push when a pop frees a slot in the same cycle.
    push_ok  = push_i && ((count_q != CNT_W'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      // New head comes from the write port when it lands on the next read slot.
      if (count_d != '0) begin
        head_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? data_i : mem_q[rd_ptr_d];
      end
    end
  end

  // State and storage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/pe_result_drain.sv
// Aligns skewed per-column PE results into rows on a valid/ready stream.
// Ports: iClk/iRstN clock and async active-low reset; iResult/iResultValid
// per-lane data and strobes; iFlush clears lanes, delay line and overflow;
// iReady consumer accept; oRow head of every lane; oValid all lanes non-empty;
// oOverflow sticky drop flag; oLevel number of complete rows.
module pe_result_drain
  import pe_pkg::*;
#(
  parameter int unsigned ARRAY_NUM = 3,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned VALID_DLY = 1
) (
  input  logic                          iClk,
  input  logic                          iRstN,
  input  logic [DATA_W*ARRAY_NUM-1:0]   iResult,
  input  logic [ARRAY_NUM-1:0]          iResultValid,
  input  logic                          iFlush,
  input  logic                          iReady,
  output logic [DATA_W*ARRAY_NUM-1:0]   oRow,
  output logic                          oValid,
  output logic                          oOverflow,
  output logic [$clog2(DEPTH):0]        oLevel
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [ARRAY_NUM-1:0] push_vld;
  logic [ARRAY_NUM-1:0] lane_full;
  logic [ARRAY_NUM-1:0] lane_empty;
  logic [LVL_W-1:0]     lane_cnt [ARRAY_NUM];
  logic [LVL_W-1:0]     level;
  logic                 pop;
  logic                 ovf_q, ovf_d;

  // Strobe delay line so each push lines up with its stable result data.
  if (VALID_DLY == 0) begin : g_no_dly
    assign push_vld = iResultValid;
  end else begin : g_dly
    logic [ARRAY_NUM-1:0] dly_q [VALID_DLY];

    always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
        for (int j = 0; j < VALID_DLY; j++) dly_q[j] <= '0;
      end else if (iFlush) begin
        for (int j = 0; j < VALID_DLY; j++) dly_q[j] <= '0;
      end else begin
        dly_q[0] <= iResultValid;
        for (int j = 1; j < VALID_DLY; j++) dly_q[j] <= dly_q[j-1];
      end
    end

    assign push_vld = dly_q[VALID_DLY-1];
  end

  // One FIFO per lane; all lanes pop together.
  for (genvar i = 0; i < ARRAY_NUM; i++) begin : g_lane
    lane_fifo #(
      .DEPTH (DEPTH)
    ) u_lane (
      .clk_i   (iClk),
      .rst_ni  (iRstN),
      .push_i  (push_vld[i]),
      .pop_i   (pop),
      .flush_i (iFlush),
      .data_i  (iResult[i*DATA_W +: DATA_W]),
      .head_o  (oRow[i*DATA_W +: DATA_W]),
      .count_o (lane_cnt[i]),
      .full_o  (lane_full[i]),
      .empty_o (lane_empty[i])
    );
  end

  assign oValid = ~|lane_empty;
  assign pop    = oValid && iReady && !iFlush;

  // Complete rows = smallest lane occupancy.
  always_comb begin
    level = lane_cnt[0];
    for (int i = 1; i < ARRAY_NUM; i++) begin
      if (lane_cnt[i] < level) level = lane_cnt[i];
    end
  end

  assign oLevel = level;

  // Sticky overflow: a push hit a full lane with no pop to make room.
  always_comb begin
    ovf_d = ovf_q;
    if (iFlush) begin
      ovf_d = 1'b0;
    end else if ((|(push_vld & lane_full)) && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign oOverflow = ovf_q;

endmodule
